// File: rtl/ula.sv
// Mic-1 datapath ALU: operand gating, logic/arithmetic function select, a post-ALU
// shifter onto the C bus, and N/Z flags with a clocked copy for JAMN/JAMZ branching.
module ula (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [7:0]  select,
    output logic [31:0] out,
    output logic        N,
    output logic        Z,
    output logic        N_reg,
    output logic        Z_reg
);

    logic        sll8_s;
    logic        sra1_s;
    logic [1:0]  fn_s;
    logic        ena_s;
    logic        enb_s;
    logic        inva_s;
    logic        inc_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] r_s;
    logic [31:0] sh_s;

    // Logical left shift by 8 with zero fill.
    function automatic logic [31:0] shl8(input logic [31:0] v);
        shl8 = {v[23:0], 8'h00};
    endfunction

    // Arithmetic right shift by 1, replicating the sign bit.
    function automatic logic [31:0] sra1(input logic [31:0] v);
        sra1 = {v[31], v[31:1]};
    endfunction

    assign sll8_s = select[7];
    assign sra1_s = select[6];
    assign fn_s   = select[5:4];
    assign ena_s  = select[3];
    assign enb_s  = select[2];
    assign inva_s = select[1];
    assign inc_s  = select[0];

    // Operand gating: a disabled operand reads as zero; INVA applies after gating so ~0 = -1.
    always_comb begin
        a_s = 32'h0000_0000;
        b_s = 32'h0000_0000;
        if (ena_s) begin
            a_s = A;
        end else begin
            a_s = 32'h0000_0000;
        end
        if (inva_s) begin
            a_s = ~a_s;
        end else begin
            a_s = a_s;
        end
        if (enb_s) begin
            b_s = B;
        end else begin
            b_s = 32'h0000_0000;
        end
    end

    // Function select; the adder wraps modulo 2^32 and INC only matters for the sum.
    always_comb begin
        r_s = 32'h0000_0000;
        case (fn_s)
            2'b00:   r_s = a_s & b_s;
            2'b01:   r_s = a_s | b_s;
            2'b10:   r_s = ~b_s;
            2'b11:   r_s = a_s + b_s + {31'h0000_0000, inc_s};
            default: r_s = 32'h0000_0000;
        endcase
    end

    // Shifter: when both shifts are requested, the left shift happens before the right shift.
    always_comb begin
        sh_s = r_s;
        if (sll8_s && sra1_s) begin
            sh_s = sra1(shl8(r_s));
        end else if (sll8_s) begin
            sh_s = shl8(r_s);
        end else if (sra1_s) begin
            sh_s = sra1(r_s);
        end else begin
            sh_s = r_s;
        end
    end

    assign out = sh_s;
    assign N   = r_s[31];
    assign Z   = (r_s == 32'h0000_0000);

    // Flag register sampled by the microsequencer on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            N_reg <= 1'b0;
            Z_reg <= 1'b0;
        end else begin
            N_reg <= N;
            Z_reg <= Z;
        end
    end

endmodule

// File: tb/tb_ula.sv
// Scoreboard bench for ula: stimulus queues hand-computed expectations, a negedge monitor
// pops and compares combinational outputs and the flag register.
module tb_ula;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  select;
    logic [31:0] out;
    logic        N;
    logic        Z;
    logic        N_reg;
    logic        Z_reg;

    int tests;
    int failed;

    typedef struct {
        string       name;
        logic [31:0] eout;
        logic        en;
        logic        ez;
        bit          has_reg;
        logic        enr;
        logic        ezr;
    } exp_t;

    exp_t sb[$];

    // Expected flags latched by the previous vector, used to predict N_reg/Z_reg.
    logic prev_n;
    logic prev_z;
    logic prev_rst;
    bit   prev_valid;

    ula dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .select (select),
        .out    (out),
        .N      (N),
        .Z      (Z),
        .N_reg  (N_reg),
        .Z_reg  (Z_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge and queue its expected response.
    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] sel, input logic rst,
                         input logic [31:0] eout, input logic en, input logic ez);
        exp_t e;
        @(posedge clk);
        #1;
        e.name    = name;
        e.eout    = eout;
        e.en      = en;
        e.ez      = ez;
        e.has_reg = prev_valid;
        e.enr     = prev_rst ? 1'b0 : prev_n;
        e.ezr     = prev_rst ? 1'b0 : prev_z;
        A      = a;
        B      = b;
        select = sel;
        reset  = rst;
        sb.push_back(e);
        prev_n     = en;
        prev_z     = ez;
        prev_rst   = rst;
        prev_valid = 1'b1;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32({e.name, ".out"}, out, e.eout);
            check1({e.name, ".N"}, N, e.en);
            check1({e.name, ".Z"}, Z, e.ez);
            if (e.has_reg) begin
                check1({e.name, ".N_reg"}, N_reg, e.enr);
                check1({e.name, ".Z_reg"}, Z_reg, e.ezr);
            end
        end
    end

    initial begin
        tests      = 0;
        failed     = 0;
        prev_n     = 1'b0;
        prev_z     = 1'b0;
        prev_rst   = 1'b0;
        prev_valid = 1'b0;
        reset      = 1'b1;
        A          = 32'h0000_0000;
        B          = 32'h0000_0000;
        select     = 8'h00;

        // Reset is held for this vector; out/N/Z must still be combinational.
        apply("rst_pass_a",  32'h0000_0001, 32'h0000_0002, 8'h18, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        apply("pass_a",      32'h0000_0001, 32'h0000_0002, 8'h18, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        apply("pass_b",      32'h0000_0001, 32'h0000_0002, 8'h14, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        apply("not_a",       32'h0000_0001, 32'h0000_0002, 8'h1A, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        apply("not_b",       32'h0000_0001, 32'h0000_0002, 8'h2C, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0);
        apply("a_plus_b",    32'h0000_0001, 32'h0000_0002, 8'h3C, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        apply("a_plus_b_1",  32'h0000_0001, 32'h0000_0002, 8'h3D, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        apply("a_plus_1",    32'h0000_0001, 32'h0000_0002, 8'h39, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        apply("b_plus_1",    32'h0000_0001, 32'h0000_0002, 8'h35, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        apply("b_minus_a",   32'h0000_0001, 32'h0000_0002, 8'h3F, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        apply("b_minus_1",   32'h0000_0001, 32'h0000_0002, 8'h36, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        apply("neg_a",       32'h0000_0001, 32'h0000_0002, 8'h3B, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("a_and_b",     32'h0000_0001, 32'h0000_0002, 8'h0C, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        apply("a_or_b",      32'h0000_0001, 32'h0000_0002, 8'h1C, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        apply("const_0",     32'h0000_0001, 32'h0000_0002, 8'h10, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        apply("const_1",     32'h0000_0001, 32'h0000_0002, 8'h31, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        apply("const_m1",    32'h0000_0001, 32'h0000_0002, 8'h32, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("const_0_b",   32'h0000_0001, 32'h0000_0002, 8'h10, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        apply("sra1",        32'h8000_0001, 32'h0000_0002, 8'h58, 1'b0, 32'hC000_0000, 1'b1, 1'b0);
        apply("sll8",        32'h8000_0001, 32'h0000_0002, 8'h98, 1'b0, 32'h0000_0100, 1'b1, 1'b0);
        apply("sll8_sra1",   32'h8000_0001, 32'h0000_0002, 8'hD8, 1'b0, 32'h0000_0080, 1'b1, 1'b0);
        apply("wrap",        32'hFFFF_FFFF, 32'h0000_0002, 8'h39, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        apply("rst_mid",     32'h0000_0001, 32'h0000_0002, 8'h32, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("after_rst",   32'h0000_0001, 32'h0000_0002, 8'h32, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("tail",        32'h0000_0001, 32'h0000_0002, 8'h18, 1'b0, 32'h0000_0001, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        tests = tests + 1;
        if (sb.size() != 0) begin
            failed = failed + 1;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
